// File: rtl/unified_mem_arbiter.sv
// Single-port bus arbiter between the fetch and data ports of openmips.
// Data port wins when both wait; results are parked in per-port hold
// registers until the owning pipeline stage advances.
module unified_mem_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              if_ce_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_data_o,
   output logic              if_stallreq_o,
   input  logic              mem_ce_i,
   input  logic              mem_we_i,
   input  logic [3:0]        mem_sel_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              mem_stallreq_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [3:0]        bus_sel_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_data_o,
   input  logic [DATA_W-1:0] bus_data_i,
   input  logic              bus_ack_i,
   output logic              bus_err_o
);

   localparam int MTAG_W = ADDR_W + 5;
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY_MEM, BUSY_IF} state_t;

   state_t              state_q, state_d;
   logic                bus_req_q, bus_req_d;
   logic                bus_we_q, bus_we_d;
   logic [3:0]          bus_sel_q, bus_sel_d;
   logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0]   bus_data_q, bus_data_d;
   logic [15:0]         cnt_q, cnt_d;
   logic                err_q, err_d;

   logic                if_vld_q, if_vld_d;
   logic [ADDR_W-1:0]   if_tag_q, if_tag_d;
   logic [DATA_W-1:0]   if_dat_q, if_dat_d;
   logic                mem_vld_q, mem_vld_d;
   logic [MTAG_W-1:0]   mem_tag_q, mem_tag_d;
   logic [DATA_W-1:0]   mem_dat_q, mem_dat_d;

   logic [MTAG_W-1:0]   mem_key;
   logic                if_match, mem_match;
   logic [DATA_W-1:0]   rdata;
   logic                stall_unused;

   // Only the PC-hold and MEM-hold bits of the stall vector matter here.
   assign stall_unused = ^{stall[5], stall[3:1]};

   assign mem_key   = {mem_addr_i, mem_we_i, mem_sel_i};
   assign if_match  = if_vld_q  && (if_tag_q  == if_addr_i);
   assign mem_match = mem_vld_q && (mem_tag_q == mem_key);

   assign if_stallreq_o  = !rst && if_ce_i  && !if_match;
   assign mem_stallreq_o = !rst && mem_ce_i && !mem_match;
   assign if_data_o      = if_match  ? if_dat_q  : '0;
   assign mem_data_o     = mem_match ? mem_dat_q : '0;

   assign bus_req_o  = bus_req_q;
   assign bus_we_o   = bus_we_q;
   assign bus_sel_o  = bus_sel_q;
   assign bus_addr_o = bus_addr_q;
   assign bus_data_o = bus_data_q;
   assign bus_err_o  = err_q;

   // Next-state logic: grant from IDLE, complete on ack or timeout, consume holds.
   always_comb begin
      state_d    = state_q;
      bus_req_d  = bus_req_q;
      bus_we_d   = bus_we_q;
      bus_sel_d  = bus_sel_q;
      bus_addr_d = bus_addr_q;
      bus_data_d = bus_data_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      if_vld_d   = if_vld_q;
      if_tag_d   = if_tag_q;
      if_dat_d   = if_dat_q;
      mem_vld_d  = mem_vld_q;
      mem_tag_d  = mem_tag_q;
      mem_dat_d  = mem_dat_q;
      rdata      = '0;

      // A matched hold is used up once its stage is allowed to advance.
      if (if_match && !stall[0])  if_vld_d  = 1'b0;
      if (mem_match && !stall[4]) mem_vld_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (mem_stallreq_o) begin
               state_d    = BUSY_MEM;
               bus_req_d  = 1'b1;
               bus_we_d   = mem_we_i;
               bus_sel_d  = mem_sel_i;
               bus_addr_d = mem_addr_i;
               bus_data_d = mem_data_i;
            end else if (if_stallreq_o) begin
               state_d    = BUSY_IF;
               bus_req_d  = 1'b1;
               bus_we_d   = 1'b0;
               bus_sel_d  = 4'b1111;
               bus_addr_d = if_addr_i;
               bus_data_d = '0;
            end
         end
         BUSY_MEM, BUSY_IF: begin
            cnt_d = cnt_q + 16'd1;
            if (bus_ack_i || (cnt_q == CNT_LAST)) begin
               // The tag is the latched bus request, so a requester that moved
               // on while we were busy never matches this stale result.
               if (bus_ack_i && !bus_we_q) rdata = bus_data_i;
               if (!bus_ack_i) err_d = 1'b1;
               state_d   = IDLE;
               bus_req_d = 1'b0;
               cnt_d     = '0;
               if (state_q == BUSY_MEM) begin
                  mem_vld_d = 1'b1;
                  mem_tag_d = {bus_addr_q, bus_we_q, bus_sel_q};
                  mem_dat_d = rdata;
               end else begin
                  if_vld_d = 1'b1;
                  if_tag_d = bus_addr_q;
                  if_dat_d = rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state and bus outputs, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bus_req_q  <= 1'b0;
         bus_we_q   <= 1'b0;
         bus_sel_q  <= '0;
         bus_addr_q <= '0;
         bus_data_q <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         if_vld_q   <= 1'b0;
         mem_vld_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bus_req_q  <= bus_req_d;
         bus_we_q   <= bus_we_d;
         bus_sel_q  <= bus_sel_d;
         bus_addr_q <= bus_addr_d;
         bus_data_q <= bus_data_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         if_vld_q   <= if_vld_d;
         mem_vld_q  <= mem_vld_d;
      end
   end

   // Hold tags and data; meaningless while the valid bit is clear.
   always_ff @(posedge clk) begin
      if_tag_q  <= if_tag_d;
      if_dat_q  <= if_dat_d;
      mem_tag_q <= mem_tag_d;
      mem_dat_q <= mem_dat_d;
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (TIMEOUT=4).
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        if_ce_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        if_stallreq_o;
   logic        mem_ce_i;
   logic        mem_we_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_data_i;
   logic [31:0] mem_data_o;
   logic        mem_stallreq_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_data_o;
   logic [31:0] bus_data_i;
   logic        bus_ack_i;
   logic        bus_err_o;

   int checks = 0;
   int errors = 0;

   unified_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
      .if_stallreq_o(if_stallreq_o),
      .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
      .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
      .mem_stallreq_o(mem_stallreq_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
      .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
      .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall = '0;
      if_ce_i = 1'b1; if_addr_i = 32'h100;
      mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0;
      mem_addr_i = '0; mem_data_i = '0;
      bus_data_i = '0; bus_ack_i = 1'b0;
      cyc(); cyc(); #1;
      // Reset state: stall requests suppressed while rst is high
      chk("rst_bus_req", 32'(bus_req_o), 32'd0);
      chk("rst_err", 32'(bus_err_o), 32'd0);
      chk("rst_if_stallreq", 32'(if_stallreq_o), 32'd0);
      chk("rst_if_data", if_data_o, 32'd0);

      // Fetch only
      rst = 1'b0; stall = 6'b000001; #1;
      chk("f_stall_n", 32'(if_stallreq_o), 32'd1);
      chk("f_req_n", 32'(bus_req_o), 32'd0);
      cyc(); #1;
      chk("f_req_n1", 32'(bus_req_o), 32'd1);
      chk("f_addr", bus_addr_o, 32'h100);
      chk("f_sel", 32'(bus_sel_o), 32'hF);
      chk("f_we", 32'(bus_we_o), 32'd0);
      chk("f_stall_n1", 32'(if_stallreq_o), 32'd1);
      cyc();
      bus_ack_i = 1'b1; bus_data_i = 32'h3C010001; #1;
      chk("f_stall_n2", 32'(if_stallreq_o), 32'd1);
      cyc();
      bus_ack_i = 1'b0; bus_data_i = '0; #1;
      chk("f_req_done", 32'(bus_req_o), 32'd0);
      chk("f_stall_n3", 32'(if_stallreq_o), 32'd0);
      chk("f_data", if_data_o, 32'h3C010001);
      cyc(); #1;
      chk("f_data_held", if_data_o, 32'h3C010001);
      stall = 6'b000000;
      cyc(); #1;
      chk("f_consumed_stall", 32'(if_stallreq_o), 32'd1);
      chk("f_consumed_data", if_data_o, 32'd0);
      if_ce_i = 1'b0;
      cyc(); #1;
      chk("f_no_regrant", 32'(bus_req_o), 32'd0);

      // Simultaneous fetch and load: load first
      stall = 6'b011111;
      if_ce_i = 1'b1; if_addr_i = 32'h104;
      mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h2000; #1;
      chk("s_if_stall", 32'(if_stallreq_o), 32'd1);
      chk("s_mem_stall", 32'(mem_stallreq_o), 32'd1);
      cyc(); #1;
      chk("s_req1", 32'(bus_req_o), 32'd1);
      chk("s_addr1", bus_addr_o, 32'h2000);
      chk("s_we1", 32'(bus_we_o), 32'd0);
      cyc();
      chk("s_req1_wait", 32'(bus_req_o), 32'd1);
      bus_ack_i = 1'b1; bus_data_i = 32'hDEADBEEF;
      cyc();
      bus_ack_i = 1'b0; bus_data_i = '0; #1;
      chk("s_idle_gap", 32'(bus_req_o), 32'd0);
      chk("s_mem_data", mem_data_o, 32'hDEADBEEF);
      chk("s_mem_stall_lo", 32'(mem_stallreq_o), 32'd0);
      chk("s_if_still_stall", 32'(if_stallreq_o), 32'd1);
      chk("s_if_data_none", if_data_o, 32'd0);
      cyc(); #1;
      chk("s_req2", 32'(bus_req_o), 32'd1);
      chk("s_addr2", bus_addr_o, 32'h104);
      chk("s_sel2", 32'(bus_sel_o), 32'hF);
      chk("s_mem_held", mem_data_o, 32'hDEADBEEF);
      bus_ack_i = 1'b1; bus_data_i = 32'h24020005;
      cyc();
      bus_ack_i = 1'b0; bus_data_i = '0; #1;
      chk("s_if_data", if_data_o, 32'h24020005);
      chk("s_if_stall_lo", 32'(if_stallreq_o), 32'd0);
      chk("s_mem_data2", mem_data_o, 32'hDEADBEEF);
      stall = 6'b000000;
      cyc(); #1;
      chk("s_mem_consumed", 32'(mem_stallreq_o), 32'd1);
      chk("s_if_consumed", 32'(if_stallreq_o), 32'd1);
      if_ce_i = 1'b0; mem_ce_i = 1'b0;
      cyc(); #1;
      chk("s_quiet", 32'(bus_req_o), 32'd0);

      // Store
      mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
      mem_addr_i = 32'h2004; mem_data_i = 32'h0000ABCD; #1;
      chk("w_stall", 32'(mem_stallreq_o), 32'd1);
      cyc(); #1;
      chk("w_req", 32'(bus_req_o), 32'd1);
      chk("w_we", 32'(bus_we_o), 32'd1);
      chk("w_sel", 32'(bus_sel_o), 32'h3);
      chk("w_addr", bus_addr_o, 32'h2004);
      chk("w_wdata", bus_data_o, 32'h0000ABCD);
      bus_ack_i = 1'b1; bus_data_i = 32'h99999999;
      cyc();
      bus_ack_i = 1'b0; bus_data_i = '0; #1;
      chk("w_stall_lo", 32'(mem_stallreq_o), 32'd0);
      chk("w_rdata_zero", mem_data_o, 32'd0);
      chk("w_req_lo", 32'(bus_req_o), 32'd0);
      mem_ce_i = 1'b0; mem_we_i = 1'b0;
      cyc();

      // Redirect while fetch in flight
      if_ce_i = 1'b1; if_addr_i = 32'h108;
      cyc(); #1;
      chk("r_addr_old", bus_addr_o, 32'h108);
      if_addr_i = 32'h200; #1;
      chk("r_stall", 32'(if_stallreq_o), 32'd1);
      cyc();
      chk("r_addr_stable", bus_addr_o, 32'h108);
      bus_ack_i = 1'b1; bus_data_i = 32'h11111111;
      cyc();
      bus_ack_i = 1'b0; bus_data_i = '0; #1;
      chk("r_stale_stall", 32'(if_stallreq_o), 32'd1);
      chk("r_stale_data", if_data_o, 32'd0);
      cyc(); #1;
      chk("r_req_new", 32'(bus_req_o), 32'd1);
      chk("r_addr_new", bus_addr_o, 32'h200);
      bus_ack_i = 1'b1; bus_data_i = 32'h22222222;
      cyc();
      bus_ack_i = 1'b0; bus_data_i = '0; #1;
      chk("r_new_data", if_data_o, 32'h22222222);
      chk("r_new_stall_lo", 32'(if_stallreq_o), 32'd0);
      if_ce_i = 1'b0;
      cyc();

      // Timeout after 4 busy cycles
      mem_ce_i = 1'b1; mem_sel_i = 4'hF; mem_addr_i = 32'h3000;
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         chk("t_req_busy", 32'(bus_req_o), 32'd1);
         chk("t_err_pre", 32'(bus_err_o), 32'd0);
      end
      cyc(); #1;
      chk("t_req_lo", 32'(bus_req_o), 32'd0);
      chk("t_err", 32'(bus_err_o), 32'd1);
      chk("t_stall_lo", 32'(mem_stallreq_o), 32'd0);
      chk("t_data_zero", mem_data_o, 32'd0);
      mem_ce_i = 1'b0;
      cyc(); cyc(); #1;
      chk("t_err_sticky", 32'(bus_err_o), 32'd1);

      // Reset mid-transaction, then late ack in IDLE
      mem_ce_i = 1'b1; mem_addr_i = 32'h4000;
      cyc(); #1;
      chk("x_req", 32'(bus_req_o), 32'd1);
      rst = 1'b1;
      cyc(); #1;
      chk("x_req_lo", 32'(bus_req_o), 32'd0);
      chk("x_err_clr", 32'(bus_err_o), 32'd0);
      chk("x_stall_rst", 32'(mem_stallreq_o), 32'd0);
      rst = 1'b0; mem_ce_i = 1'b0;
      bus_ack_i = 1'b1; bus_data_i = 32'h55555555;
      cyc();
      bus_ack_i = 1'b0; bus_data_i = '0;
      mem_ce_i = 1'b1; #1;
      chk("x_no_hold_stall", 32'(mem_stallreq_o), 32'd1);
      chk("x_no_hold_data", mem_data_o, 32'd0);
      chk("x_idle", 32'(bus_req_o), 32'd0);
      mem_ce_i = 1'b0;
      cyc(); #1;
      chk("x_err_final", 32'(bus_err_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one external single-ported 32-bit memory bus between the fetch port (pc_reg/IF) and the data port (MEM stage) of openmips.
- Presents the same ce/addr/data interfaces the core already drives toward separate ROM/RAM, so it drops in between openmips and a unified memory.
- Sequences variable-latency req/ack bus transactions, holds returned data until the owning stage advances, and raises stall requests for ctrl.

Parameters:
DATA_W, 32, data and word width
ADDR_W, 32, address width
TIMEOUT, 255, bus cycles without ack before a transaction is force-completed with an error (1..2^16-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  6  ctrl stall vector; bit0 = PC hold, bit4 = MEM-stage hold
if_ce_i  in  1  fetch request
if_addr_i  in  ADDR_W  fetch address
if_data_o  out  DATA_W  fetched word
if_stallreq_o  out  1  fetch not yet served
mem_ce_i  in  1  data request
mem_we_i  in  1  1 = store
mem_sel_i  in  4  byte lanes
mem_addr_i  in  ADDR_W  data address
mem_data_i  in  DATA_W  store data
mem_data_o  out  DATA_W  load data
mem_stallreq_o  out  1  data access not yet served
bus_req_o  out  1  bus transaction valid
bus_we_o  out  1  bus write
bus_sel_o  out  4  bus byte lanes
bus_addr_o  out  ADDR_W  bus address
bus_data_o  out  DATA_W  bus write data
bus_data_i  in  DATA_W  bus read data
bus_ack_i  in  1  transaction complete, one-cycle pulse
bus_err_o  out  1  sticky timeout flag

Behaviour:
- Clock, reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all registered outputs 0, state IDLE, both hold registers invalid, timeout counter 0.
- Reset mid-transaction: the FSM returns to IDLE and bus_req_o is 0 the next cycle. Any later bus_ack_i is ignored.
- Hold registers:
  - IF hold: valid bit, tag = address, data.
  - MEM hold: valid bit, tag = {addr, we, sel}, data.
  - A hold "matches" when it is valid and its tag equals the current inputs.
- Stall requests (combinational):
  - if_stallreq_o = if_ce_i & !IF match.
  - mem_stallreq_o = mem_ce_i & !MEM match.
  - Both are 0 during rst.
- Data outputs: if_data_o and mem_data_o are the hold data when matched, else 0. Store completions return 0.
- FSM states: IDLE, BUSY_MEM, BUSY_IF.
  - IDLE, an unmatched mem request pending: latch bus fields, go to BUSY_MEM, bus_req_o=1 from the next cycle. The data port has priority because it is the older instruction.
  - IDLE, else an unmatched fetch pending: go to BUSY_IF with bus_we_o=0, bus_sel_o=4'b1111.
  - BUSY_x: bus outputs stay stable until ack.
    - bus_ack_i=1: write bus_data_i (0 for stores) and the tag into hold x, set valid, drop bus_req_o, go to IDLE.
    - Result: at least one idle bus cycle between transactions.
  - Minimum latency: request in cycle n, bus_req_o in n+1, ack in n+1, stallreq low in n+2.
- Timeout: a counter runs in BUSY.
  - When it reaches TIMEOUT with no ack, complete as if acked with data 0, set bus_err_o (sticky until rst), go to IDLE.
  - The counter clears on every grant.
- Hold consumption:
  - IF hold is invalidated at the edge where it matches and stall[0]=0.
  - MEM hold is invalidated at the edge where it matches and stall[4]=0.
  - A matched hold persists while its stage is stalled by others.
- Stale results:
  - If the requester's inputs change while a transaction is in flight (e.g. branch redirect changes if_addr_i), the transaction still completes on the bus. Its hold is written with the old tag, so it never matches.
  - The new request is issued from IDLE afterwards.
  - An unmatched valid hold is overwritten by the next completion for that port.
- bus_ack_i in IDLE is ignored.
- Widths: all address and data paths are full-width pass-through; no arithmetic besides the counter.

Test Plan:
- Fetch only: if_ce_i=1, if_addr_i=0x100, ack one cycle after bus_req_o, bus_data_i=0x3C010001 -> bus_addr_o=0x100, sel=4'hF, if_stallreq_o high 3 cycles, then if_data_o=0x3C010001; hold cleared when stall[0]=0.
- Simultaneous: fetch 0x104 and load 0x2000 in the same cycle -> load issued first, then fetch after one idle cycle. mem_data_o=0xDEADBEEF (ack 2nd cycle); if_data_o valid only after both transactions.
- Store: mem_we_i=1, sel=4'b0011, addr 0x2004, data 0x0000ABCD -> bus_we_o=1 with identical fields; mem_stallreq_o drops the cycle after ack; mem_data_o=0.
- Redirect: fetch 0x108 in flight, if_addr_i switches to 0x200 before ack -> 0x108 data never appears; a second bus transaction at 0x200 follows.
- Timeout: TIMEOUT=4, no ack -> bus_req_o falls after 4 BUSY cycles; bus_err_o=1 and stays 1; stallreq released with data 0.
- Reset mid-transaction: rst during BUSY_MEM -> bus_req_o=0 next cycle; a late ack produces no hold update; bus_err_o=0.
